// File: rtl/tpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tpu_pkg
// Brief   : Shared state encoding, widths and helpers for the TPU front end.
// Revision: 1.0 - initial release
// ============================================================================
package tpu_pkg;

  localparam int TPU_DATA_W = 32;
  localparam int TPU_IDX_W  = 16;
  localparam int TPU_DIM_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_A    = 3'd1,
    ST_LOAD_B    = 3'd2,
    ST_START     = 3'd3,
    ST_WAIT_BUSY = 3'd4,
    ST_WAIT_DONE = 3'd5
  } state_e;

  // Number of 4-lane words needed to cover x int8 elements.
  function automatic logic [6:0] ceil4(input logic [7:0] x);
    logic [8:0] t;
    t = {1'b0, x} + 9'd3;
    return t[8:2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/tpu_word_writer.sv
`default_nettype none
// ============================================================================
// Module  : tpu_word_writer
// Brief   : Registers one accepted operand word into a buffer write triple.
// Revision: 1.0 - initial release
// ============================================================================
module tpu_word_writer
  import tpu_pkg::*;
#(
  parameter int DATA_W = TPU_DATA_W,
  parameter int IDX_W  = TPU_IDX_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              accept_i,
  input  logic [IDX_W-1:0]  index_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              wr_en_o,
  output logic [IDX_W-1:0]  index_o,
  output logic [DATA_W-1:0] data_o
);

  logic              wr_en_q;
  logic [IDX_W-1:0]  index_q;
  logic [DATA_W-1:0] data_q;

  // rst_n_i is active-high despite its name.
  always_ff @(posedge clk_i or posedge rst_n_i) begin
    if (rst_n_i) begin
      wr_en_q <= 1'b0;
      index_q <= '0;
      data_q  <= '0;
    end else begin
      wr_en_q <= accept_i;
      if (accept_i) begin
        index_q <= index_i;
        data_q  <= data_i;
      end
    end
  end

  assign wr_en_o = wr_en_q;
  assign index_o = index_q;
  assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/tpu_operand_loader.sv
`default_nettype none
// ============================================================================
// Module  : tpu_operand_loader
// Brief   : Streams packed A/B operands into the global buffers, launches the
//           TPU and reports completion or failure of each job.
// Revision: 1.0 - initial release
// ============================================================================
module tpu_operand_loader
  import tpu_pkg::*;
#(
  parameter int DATA_W        = TPU_DATA_W,
  parameter int IDX_W         = TPU_IDX_W,
  parameter int START_TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [7:0]        cfg_K_i,
  input  logic [7:0]        cfg_M_i,
  input  logic [7:0]        cfg_N_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              A_wr_en_o,
  output logic [IDX_W-1:0]  A_index_o,
  output logic [DATA_W-1:0] A_data_in_o,
  output logic              B_wr_en_o,
  output logic [IDX_W-1:0]  B_index_o,
  output logic [DATA_W-1:0] B_data_in_o,
  output logic              tpu_in_valid_o,
  output logic [7:0]        tpu_K_o,
  output logic [7:0]        tpu_M_o,
  output logic [7:0]        tpu_N_o,
  input  logic              tpu_busy_i,
  output logic              load_active_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [15:0] TMO_LAST = 16'(START_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] na_q, na_d;
  logic [IDX_W-1:0] nb_q, nb_d;
  logic [15:0]      tmr_q, tmr_d;
  logic [7:0]       dim_k_q, dim_k_d;
  logic [7:0]       dim_m_q, dim_m_d;
  logic [7:0]       dim_n_q, dim_n_d;
  logic             cfg_ready_q;
  logic             tpu_in_valid_q;
  logic             load_active_q;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             s_ready_w;
  logic             accept_w;
  logic             a_accept_w;
  logic             b_accept_w;

  assign s_ready_w  = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
  assign accept_w   = s_valid_i && s_ready_w;
  assign a_accept_w = accept_w && (state_q == ST_LOAD_A);
  assign b_accept_w = accept_w && (state_q == ST_LOAD_B);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    na_d    = na_q;
    nb_d    = nb_q;
    tmr_d   = tmr_q;
    dim_k_d = dim_k_q;
    dim_m_d = dim_m_q;
    dim_n_d = dim_n_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // cfg_ready_q is low for the first cycle out of reset, so gate on it.
        if (cfg_valid_i && cfg_ready_q) begin
          if ((cfg_K_i == 8'd0) || (cfg_M_i == 8'd0) || (cfg_N_i == 8'd0)) begin
            err_d = 1'b1;
          end else begin
            dim_k_d = cfg_K_i;
            dim_m_d = cfg_M_i;
            dim_n_d = cfg_N_i;
            na_d    = IDX_W'(cfg_K_i) * IDX_W'(ceil4(cfg_M_i));
            nb_d    = IDX_W'(cfg_K_i) * IDX_W'(ceil4(cfg_N_i));
            cnt_d   = '0;
            tmr_d   = '0;
            state_d = ST_LOAD_A;
          end
        end
      end
      ST_LOAD_A: begin
        if (accept_w) begin
          if (cnt_q == na_q - IDX_W'(1)) begin
            cnt_d   = '0;
            state_d = ST_LOAD_B;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end
      ST_LOAD_B: begin
        if (accept_w) begin
          if (cnt_q == nb_q - IDX_W'(1)) begin
            cnt_d   = '0;
            tmr_d   = '0;
            state_d = ST_START;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end
      ST_START: begin
        // The timer counts from the launch cycle so the timeout lands
        // START_TIMEOUT cycles after tpu_in_valid.
        tmr_d   = tmr_q + 16'd1;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tpu_busy_i) begin
          tmr_d   = '0;
          state_d = ST_WAIT_DONE;
        end else if (tmr_q == TMO_LAST) begin
          tmr_d   = '0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      ST_WAIT_DONE: begin
        if (!tpu_busy_i) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_n_i) begin
    if (rst_n_i) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      na_q           <= '0;
      nb_q           <= '0;
      tmr_q          <= '0;
      dim_k_q        <= '0;
      dim_m_q        <= '0;
      dim_n_q        <= '0;
      cfg_ready_q    <= 1'b0;
      tpu_in_valid_q <= 1'b0;
      load_active_q  <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      na_q           <= na_d;
      nb_q           <= nb_d;
      tmr_q          <= tmr_d;
      dim_k_q        <= dim_k_d;
      dim_m_q        <= dim_m_d;
      dim_n_q        <= dim_n_d;
      cfg_ready_q    <= (state_d == ST_IDLE);
      tpu_in_valid_q <= (state_d == ST_START);
      // START carries the final B write, so the buffer mux must stay here.
      load_active_q  <= (state_d == ST_LOAD_A) || (state_d == ST_LOAD_B) ||
                        (state_d == ST_START);
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

  tpu_word_writer #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_a_writer (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .accept_i (a_accept_w),
    .index_i  (cnt_q),
    .data_i   (s_data_i),
    .wr_en_o  (A_wr_en_o),
    .index_o  (A_index_o),
    .data_o   (A_data_in_o)
  );

  tpu_word_writer #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_b_writer (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .accept_i (b_accept_w),
    .index_i  (cnt_q),
    .data_i   (s_data_i),
    .wr_en_o  (B_wr_en_o),
    .index_o  (B_index_o),
    .data_o   (B_data_in_o)
  );

  assign cfg_ready_o    = cfg_ready_q;
  assign s_ready_o      = s_ready_w;
  assign tpu_in_valid_o = tpu_in_valid_q;
  assign tpu_K_o        = dim_k_q;
  assign tpu_M_o        = dim_m_q;
  assign tpu_N_o        = dim_n_q;
  assign load_active_o  = load_active_q;
  assign done_o         = done_q;
  assign err_o          = err_q;

endmodule
`default_nettype wire
